ram_responder: RTL

//  Responder (RAM) end of the cpu_ram_if memory protocol: services word reads/writes issued on

---
 rtl/ram_responder_pkg.sv | 26 ++
 rtl/ram_responder_if.sv | 22 ++
 rtl/ram_responder_ram_array.sv | 28 ++
 rtl/ram_responder.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/ram_responder_pkg.sv
// Shared types for the RAM responder: bus word, protocol status, responder FSM states.
package ram_responder_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } rsp_state_t;

  localparam int CNT_W = 4;

  // Reload value of the latency counter; a zero latency never enters WAIT.
  function automatic logic [CNT_W-1:0] cnt_init(input int lat);
    return (lat == 0) ? '0 : CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/ram_responder_if.sv
// Initiator/responder memory bus: request (REN/WEN/addr/store) and response (load/state).
interface ram_responder_if;
  import ram_responder_pkg::*;

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (
    output ramREN, ramWEN, ramaddr, ramstore,
    input  ramload, ramstate
  );

  modport slave (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );

endinterface

// File: rtl/ram_responder_ram_array.sv
// WORDS x 32 storage with one registered read port and one write port; contents are never reset.
module ram_array
  import ram_responder_pkg::*;
#(
  parameter int WORDS = 1024,
  parameter int IDX_W = $clog2(WORDS)
) (
  input  logic             CLK,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output word_t            rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  word_t            wr_data
);

  word_t mem [WORDS];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/ram_responder.sv
// Fixed-latency word-addressed RAM responder on the cpu/ram bus.
// Optional RAM_STATS_EN adds rd_count/wr_count access counters.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int WORDS = 1024
) (
  input  logic CLK,
  input  logic nRST,
  ram_responder_if.slave bus
`ifdef RAM_STATS_EN
  ,
  output word_t rd_count,
  output word_t wr_count
`endif
);

  localparam int               IDX_W    = $clog2(WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT = cnt_init(LAT);

  rsp_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             lat_ren_reg, lat_wen_reg;
  logic [29:0]      lat_addr_reg;
  word_t            lat_store_reg;
  logic             load_valid_reg;

  ramstate_t        ram_state;
  logic             load_req;
  logic             do_access;
  logic             do_rd, do_wr;
  word_t            rd_data;

  logic             req, req_invalid, req_differs, out_of_range;
  word_t            word_idx;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^bus.ramaddr[1:0];

  assign word_idx     = {2'b00, bus.ramaddr[31:2]};
  assign out_of_range = (word_idx >= 32'(WORDS));
  assign req          = bus.ramREN | bus.ramWEN;
  assign req_invalid  = (bus.ramREN & bus.ramWEN) | (req & out_of_range);
  assign req_differs  = (bus.ramREN != lat_ren_reg) |
                        (bus.ramWEN != lat_wen_reg) |
                        (bus.ramaddr[31:2] != lat_addr_reg) |
                        (bus.ramWEN & (bus.ramstore != lat_store_reg));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load_req   = 1'b0;
    do_access  = 1'b0;
    ram_state  = FREE;
    case (state_reg)
      IDLE: begin
        if (req_invalid) begin
          ram_state = ERROR;
        end else if (req) begin
          ram_state = BUSY;
          load_req  = 1'b1;
          if (LAT == 0) begin
            do_access  = 1'b1;
            state_next = ACK;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        ram_state = BUSY;
        // An abandoned or now-illegal request returns to IDLE so the error shows next cycle.
        if (!req || req_invalid) begin
          state_next = IDLE;
        end else if (req_differs) begin
          load_req = 1'b1;
          cnt_next = CNT_INIT;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else begin
          do_access  = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        ram_state  = ACCESS;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Access uses the live request, which equals the latched one whenever do_access fires.
  assign do_rd = do_access & bus.ramREN & nRST;
  assign do_wr = do_access & bus.ramWEN & nRST;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      lat_ren_reg    <= 1'b0;
      lat_wen_reg    <= 1'b0;
      lat_addr_reg   <= '0;
      lat_store_reg  <= '0;
      load_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (load_req) begin
        lat_ren_reg   <= bus.ramREN;
        lat_wen_reg   <= bus.ramWEN;
        lat_addr_reg  <= bus.ramaddr[31:2];
        lat_store_reg <= bus.ramstore;
      end
      if (do_rd) begin
        load_valid_reg <= 1'b1;
      end
    end
  end

  ram_array #(
    .WORDS (WORDS),
    .IDX_W (IDX_W)
  ) u_ram_array (
    .CLK     (CLK),
    .rd_en   (do_rd),
    .rd_idx  (bus.ramaddr[2 +: IDX_W]),
    .rd_data (rd_data),
    .wr_en   (do_wr),
    .wr_idx  (bus.ramaddr[2 +: IDX_W]),
    .wr_data (bus.ramstore)
  );

  // The RAM output register has no reset, so ramload reads zero until the first read lands.
  assign bus.ramload  = load_valid_reg ? rd_data : '0;
  assign bus.ramstate = ram_state;

`ifdef RAM_STATS_EN
  word_t rd_count_reg, wr_count_reg;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_count_reg <= '0;
      wr_count_reg <= '0;
    end else begin
      if (do_rd) rd_count_reg <= rd_count_reg + 1'b1;
      if (do_wr) wr_count_reg <= wr_count_reg + 1'b1;
    end
  end

  assign rd_count = rd_count_reg;
  assign wr_count = wr_count_reg;
`endif

endmodule
